// File: rtl/rgb2gray_pkg.sv
// Shared constants and types for the RGB-to-gray streaming converter.
package rgb2gray_pkg;

    localparam int unsigned DEF_PIX_W  = 8;
    localparam int unsigned DEF_COEF_W = 16;

    // Default luma weights, unsigned Q0.16: 0.299 / 0.587 / 0.114.
    localparam logic [15:0] DEF_COEF_R = 16'h4C8B;
    localparam logic [15:0] DEF_COEF_G = 16'h9646;
    localparam logic [15:0] DEF_COEF_B = 16'h1D2F;

    // Coefficient update sequencing.
    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StLoad
    } cfg_state_e;

    // Width of one colour*coefficient product.
    function automatic int unsigned prod_w(input int unsigned pix_w, input int unsigned coef_w);
        return pix_w + coef_w;
    endfunction

    // Width of the three-product sum plus rounding constant.
    function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned coef_w);
        return pix_w + coef_w + 2;
    endfunction

endpackage

// File: rtl/rgb2gray_lane.sv
// One lane of the gray datapath: multiply (S1), sum+round (S2), shift+saturate (S3).
// All stages advance together on en; valid tracking lives in the parent.
module rgb2gray_lane
    import rgb2gray_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned COEF_W = DEF_COEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3*PIX_W-1:0]   rgb,
    input  logic [COEF_W-1:0]    coef_r,
    input  logic [COEF_W-1:0]    coef_g,
    input  logic [COEF_W-1:0]    coef_b,
    output logic [PIX_W-1:0]     gray
);

    localparam int unsigned ProdW = prod_w(PIX_W, COEF_W);
    localparam int unsigned SumW  = sum_w(PIX_W, COEF_W);
    localparam int unsigned ShW   = SumW - COEF_W;
    localparam logic [SumW-1:0] RoundK = SumW'(1) << (COEF_W - 1);

    logic [ProdW-1:0] prod_r_d, prod_g_d, prod_b_d;
    logic [ProdW-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic [SumW-1:0]  sum_d, sum_q;
    logic [ShW-1:0]   shifted;
    logic [PIX_W-1:0] gray_d, gray_q;

    // Next-state for all three stages.
    always_comb begin
        prod_r_d = ProdW'(rgb[3*PIX_W-1 -: PIX_W]) * ProdW'(coef_r);
        prod_g_d = ProdW'(rgb[2*PIX_W-1 -: PIX_W]) * ProdW'(coef_g);
        prod_b_d = ProdW'(rgb[PIX_W-1:0]) * ProdW'(coef_b);
        sum_d    = SumW'(prod_r_q) + SumW'(prod_g_q) + SumW'(prod_b_q) + RoundK;
        shifted  = ShW'(sum_q >> COEF_W);
        // Coefficients may sum above 1.0, so the integer part can exceed PIX_W bits.
        gray_d   = (|shifted[ShW-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
    end

    // Pipeline registers, frozen while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            sum_q    <= '0;
            gray_q   <= '0;
        end else if (en) begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            sum_q    <= sum_d;
            gray_q   <= gray_d;
        end
    end

    assign gray = gray_q;

endmodule

// File: rtl/rgb2gray_stream.sv
// Multi-lane RGB-to-gray stream converter with valid/ready, last propagation and
// programmable coefficients applied only once the pipeline has drained.
// Optional frame statistics outputs when RGB2GRAY_STREAM_STATS_EN is defined.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int unsigned       PIX_W      = DEF_PIX_W,
    parameter int unsigned       COEF_W     = DEF_COEF_W,
    parameter int unsigned       LANES      = 1,
    parameter logic [COEF_W-1:0] RST_COEF_R = DEF_COEF_R,
    parameter logic [COEF_W-1:0] RST_COEF_G = DEF_COEF_G,
    parameter logic [COEF_W-1:0] RST_COEF_B = DEF_COEF_B
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES*3*PIX_W-1:0] in_rgb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [LANES*PIX_W-1:0]   out_gray,
    input  logic                     cfg_we,
    input  logic [3*COEF_W-1:0]      cfg_coef,
    output logic                     cfg_busy
`ifdef RGB2GRAY_STREAM_STATS_EN
    ,
    output logic [31:0]              stat_pix_cnt,
    output logic [PIX_W-1:0]         stat_gray_max,
    output logic [PIX_W-1:0]         stat_gray_min,
    output logic                     stat_valid
`endif
);

    logic en, accept;
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_last_q, s2_last_q, s3_last_q;

    cfg_state_e          state_q;
    logic                cfg_busy_q;
    logic [3*COEF_W-1:0] pend_q, load_coef;
    logic [COEF_W-1:0]   coef_r_q, coef_g_q, coef_b_q;

    assign en       = !s3_valid_q || out_ready;
    assign in_ready = en && (state_q == StRun);
    assign accept   = in_valid && in_ready;

    // A write arriving in the LOAD cycle still wins over the older pending value.
    assign load_coef = cfg_we ? cfg_coef : pend_q;

    // Valid/last shift alongside the lane datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && in_last;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
        end
    end

    // Config FSM: latch pending, drain in-flight beats, then swap coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            cfg_busy_q <= 1'b0;
            pend_q     <= {RST_COEF_R, RST_COEF_G, RST_COEF_B};
            coef_r_q   <= RST_COEF_R;
            coef_g_q   <= RST_COEF_G;
            coef_b_q   <= RST_COEF_B;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (cfg_we) begin
                        pend_q     <= cfg_coef;
                        state_q    <= StDrain;
                        cfg_busy_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (cfg_we) pend_q <= cfg_coef;
                    if (!s1_valid_q && !s2_valid_q && !s3_valid_q) state_q <= StLoad;
                end
                StLoad: begin
                    pend_q     <= load_coef;
                    coef_r_q   <= load_coef[3*COEF_W-1 -: COEF_W];
                    coef_g_q   <= load_coef[2*COEF_W-1 -: COEF_W];
                    coef_b_q   <= load_coef[COEF_W-1:0];
                    state_q    <= StRun;
                    cfg_busy_q <= 1'b0;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rgb2gray_lane #(
            .PIX_W  (PIX_W),
            .COEF_W (COEF_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .rgb    (in_rgb[k*3*PIX_W +: 3*PIX_W]),
            .coef_r (coef_r_q),
            .coef_g (coef_g_q),
            .coef_b (coef_b_q),
            .gray   (out_gray[k*PIX_W +: PIX_W])
        );
    end

    assign out_valid = s3_valid_q;
    assign out_last  = s3_last_q;
    assign cfg_busy  = cfg_busy_q;

`ifdef RGB2GRAY_STREAM_STATS_EN
    logic             out_xfer;
    logic [PIX_W-1:0] beat_max, beat_min, base_max, base_min;
    logic [31:0]      base_cnt;
    logic [31:0]      cnt_q;
    logic [PIX_W-1:0] max_q, min_q;
    logic             stat_valid_q;

    assign out_xfer = s3_valid_q && out_ready;

    // Per-beat extremes, and accumulators restarted the cycle after a frame report.
    always_comb begin
        beat_max = '0;
        beat_min = '1;
        for (int k = 0; k < LANES; k++) begin
            if (out_gray[k*PIX_W +: PIX_W] > beat_max) beat_max = out_gray[k*PIX_W +: PIX_W];
            if (out_gray[k*PIX_W +: PIX_W] < beat_min) beat_min = out_gray[k*PIX_W +: PIX_W];
        end
        base_cnt = stat_valid_q ? '0 : cnt_q;
        base_max = stat_valid_q ? '0 : max_q;
        base_min = stat_valid_q ? '1 : min_q;
    end

    // Frame accumulators; the totals are visible while stat_valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            max_q        <= '0;
            min_q        <= '1;
            stat_valid_q <= 1'b0;
        end else begin
            stat_valid_q <= out_xfer && s3_last_q;
            if (out_xfer) begin
                cnt_q <= base_cnt + 32'(LANES);
                max_q <= (beat_max > base_max) ? beat_max : base_max;
                min_q <= (beat_min < base_min) ? beat_min : base_min;
            end else begin
                cnt_q <= base_cnt;
                max_q <= base_max;
                min_q <= base_min;
            end
        end
    end

    assign stat_pix_cnt  = cnt_q;
    assign stat_gray_max = max_q;
    assign stat_gray_min = min_q;
    assign stat_valid    = stat_valid_q;
`endif

endmodule
